sram_arbiter: RTL and testbench

- Shares the single 8-bit asynchronous SRAM between three requesters: CGA/video fetch (port V, read-only), the CPU bus cycle (port C), and the loader/DMA path (port D).
- Sequences every SRAM access through setup, strobe and recovery phases, and returns read data with a one-cycle acknowledge.
- Sits in the CHIPSET memory path. It drives SRAM_ADDR and SRAM_WE_n. The top level builds the SRAM_DATA tristate from the dq_o and dq_oe outputs.

---
 rtl/sram_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Three-port arbiter and access sequencer for the shared 8-bit asynchronous SRAM.
// Video (read-only), CPU and DMA ports; each access runs SETUP, ACCESS x WAIT_CYCLES, DONE.
module sram_arbiter #(
   parameter int ADDR_W      = 21,
   parameter int WAIT_CYCLES = 2,
   parameter int VID_MAX     = 4
) (
   input  logic              clk_chipset,
   input  logic              reset,
   input  logic              v_req,
   input  logic [ADDR_W-1:0] v_addr,
   output logic              v_ack,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [7:0]        c_wdata,
   output logic              c_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [7:0]        d_wdata,
   output logic              d_ack,
   output logic [7:0]        rdata,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [7:0]        sram_dq_i,
   output logic [7:0]        sram_dq_o,
   output logic              sram_dq_oe,
   output logic              sram_we_n,
   output logic              busy,
   output logic [1:0]        grant,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int              VW        = $clog2(VID_MAX + 1);
   localparam logic [VW-1:0]   VID_TOP   = VW'(VID_MAX);
   localparam logic [3:0]      WCNT_LAST = 4'(WAIT_CYCLES - 1);
   localparam logic [1:0]      OWN_NONE  = 2'd0;
   localparam logic [1:0]      OWN_V     = 2'd1;
   localparam logic [1:0]      OWN_C     = 2'd2;
   localparam logic [1:0]      OWN_D     = 2'd3;

   state_t              state_q, state_d;
   logic [3:0]          wcnt_q, wcnt_d;
   logic                we_q, we_d;
   logic                rr_last_q, rr_last_d;   // 1 = D was the last C/D winner
   logic [VW-1:0]       vid_cnt_q, vid_cnt_d;
   logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
   logic [7:0]          sram_dq_o_q, sram_dq_o_d;
   logic                sram_dq_oe_q, sram_dq_oe_d;
   logic                sram_we_n_q, sram_we_n_d;
   logic [7:0]          rdata_q, rdata_d;
   logic                v_ack_q, v_ack_d;
   logic                c_ack_q, c_ack_d;
   logic                d_ack_q, d_ack_d;
   logic                busy_q, busy_d;
   logic [1:0]          grant_q, grant_d;
   logic                v_win, c_win, d_win;

   always_comb begin
      state_d      = state_q;
      wcnt_d       = wcnt_q;
      we_d         = we_q;
      rr_last_d    = rr_last_q;
      vid_cnt_d    = vid_cnt_q;
      sram_addr_d  = sram_addr_q;
      sram_dq_o_d  = sram_dq_o_q;
      sram_dq_oe_d = sram_dq_oe_q;
      sram_we_n_d  = sram_we_n_q;
      rdata_d      = rdata_q;
      v_ack_d      = 1'b0;
      c_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      busy_d       = busy_q;
      grant_d      = grant_q;

      // Video has priority until it has used up its burst while C or D waits.
      v_win = v_req && !((vid_cnt_q == VID_TOP) && (c_req || d_req));
      c_win = !v_win && c_req && (!d_req || rr_last_q);
      d_win = !v_win && d_req && (!c_req || !rr_last_q);

      case (state_q)
         IDLE: begin
            if (v_win || c_win || d_win) begin
               state_d     = SETUP;
               busy_d      = 1'b1;
               sram_we_n_d = 1'b1;
               if (v_win) begin
                  grant_d     = OWN_V;
                  sram_addr_d = v_addr;
                  we_d        = 1'b0;
                  if (vid_cnt_q != VID_TOP) vid_cnt_d = vid_cnt_q + 1'b1;
               end else if (c_win) begin
                  grant_d      = OWN_C;
                  sram_addr_d  = c_addr;
                  we_d         = c_we;
                  sram_dq_oe_d = c_we;
                  if (c_we) sram_dq_o_d = c_wdata;
                  rr_last_d    = 1'b0;
                  vid_cnt_d    = '0;
               end else begin
                  grant_d      = OWN_D;
                  sram_addr_d  = d_addr;
                  we_d         = d_we;
                  sram_dq_oe_d = d_we;
                  if (d_we) sram_dq_o_d = d_wdata;
                  rr_last_d    = 1'b1;
                  vid_cnt_d    = '0;
               end
            end
         end
         SETUP: begin
            state_d     = ACCESS;
            wcnt_d      = '0;
            sram_we_n_d = !we_q;
         end
         ACCESS: begin
            if (wcnt_q == WCNT_LAST) begin
               state_d     = DONE;
               sram_we_n_d = 1'b1;
               if (!we_q) rdata_d = sram_dq_i;
               v_ack_d = (grant_q == OWN_V);
               c_ack_d = (grant_q == OWN_C);
               d_ack_d = (grant_q == OWN_D);
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            grant_d      = OWN_NONE;
            sram_dq_oe_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_chipset) begin
      if (reset) begin
         state_q      <= IDLE;
         wcnt_q       <= '0;
         we_q         <= 1'b0;
         rr_last_q    <= 1'b1;
         vid_cnt_q    <= '0;
         sram_addr_q  <= '0;
         sram_dq_o_q  <= '0;
         sram_dq_oe_q <= 1'b0;
         sram_we_n_q  <= 1'b1;
         rdata_q      <= '0;
         v_ack_q      <= 1'b0;
         c_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         busy_q       <= 1'b0;
         grant_q      <= OWN_NONE;
      end else begin
         state_q      <= state_d;
         wcnt_q       <= wcnt_d;
         we_q         <= we_d;
         rr_last_q    <= rr_last_d;
         vid_cnt_q    <= vid_cnt_d;
         sram_addr_q  <= sram_addr_d;
         sram_dq_o_q  <= sram_dq_o_d;
         sram_dq_oe_q <= sram_dq_oe_d;
         sram_we_n_q  <= sram_we_n_d;
         rdata_q      <= rdata_d;
         v_ack_q      <= v_ack_d;
         c_ack_q      <= c_ack_d;
         d_ack_q      <= d_ack_d;
         busy_q       <= busy_d;
         grant_q      <= grant_d;
      end
   end

   assign v_ack      = v_ack_q;
   assign c_ack      = c_ack_q;
   assign d_ack      = d_ack_q;
   assign rdata      = rdata_q;
   assign sram_addr  = sram_addr_q;
   assign sram_dq_o  = sram_dq_o_q;
   assign sram_dq_oe = sram_dq_oe_q;
   assign sram_we_n  = sram_we_n_q;
   assign busy       = busy_q;
   assign grant      = grant_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: single-access vector table, arbitration sequences, reset abort.
// Acks are matched against an expected queue of {owner, rdata} entries.
module tb_sram_arbiter;

   localparam int ADDR_W = 21;
   localparam int W      = 2;

   logic              clk_chipset = 1'b0;
   logic              reset;
   logic              v_req, c_req, d_req, c_we, d_we;
   logic [ADDR_W-1:0] v_addr, c_addr, d_addr;
   logic [7:0]        c_wdata, d_wdata;
   logic              v_ack, c_ack, d_ack;
   logic [7:0]        rdata;
   logic [ADDR_W-1:0] sram_addr;
   logic [7:0]        sram_dq_i, sram_dq_o;
   logic              sram_dq_oe, sram_we_n, busy;
   logic [1:0]        grant, dbg_state;

   sram_arbiter #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W), .VID_MAX(4)) dut (
      .clk_chipset(clk_chipset), .reset(reset),
      .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
      .rdata(rdata), .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
      .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .busy(busy), .grant(grant),
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk_chipset = ~clk_chipset;

   // ---------------- async SRAM model (low address byte decoded) ----------------
   logic [7:0] mem     [0:255];
   bit         written [0:255];
   assign sram_dq_i = written[sram_addr[7:0]] ? mem[sram_addr[7:0]] : (sram_addr[7:0] ^ 8'hE0);
   always @(posedge sram_we_n) begin
      if (!reset) begin
         mem[sram_addr[7:0]]     = sram_dq_o;
         written[sram_addr[7:0]] = 1'b1;
      end
   end

   // ---------------- counters and checking ----------------
   int    tests_run    = 0;
   int    tests_failed = 0;
   string ctx          = "init";

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s/%s: got %0h expected %0h", ctx, name, act, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [9:0] exp_q[$];
   logic [1:0] ack_log[$];

   always @(negedge clk_chipset) begin
      logic [1:0] owner;
      logic [9:0] e;
      if (v_ack || c_ack || d_ack) begin
         check("one_ack", $countones({v_ack, c_ack, d_ack}), 1);
         owner = v_ack ? 2'd1 : (c_ack ? 2'd2 : 2'd3);
         ack_log.push_back(owner);
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s/sb_unexpected: ack from port %0d, none expected", ctx, owner);
         end else begin
            e = exp_q.pop_front();
            check("sb_owner", owner, e[9:8]);
            check("sb_rdata", rdata, e[7:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_req(input logic [1:0] port, input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [7:0] wd, input logic val);
      case (port)
         2'd1: begin v_req = val; v_addr = addr; end
         2'd2: begin c_req = val; c_we = we; c_addr = addr; c_wdata = wd; end
         2'd3: begin d_req = val; d_we = we; d_addr = addr; d_wdata = wd; end
         default: ;
      endcase
   endtask

   function automatic logic port_ack(input logic [1:0] port);
      return (port == 2'd1) ? v_ack : (port == 2'd2) ? c_ack : d_ack;
   endfunction

   task automatic apply_reset();
      @(posedge clk_chipset); #1;
      reset = 1'b1;
      v_req = 1'b0; c_req = 1'b0; d_req = 1'b0;
      @(posedge clk_chipset); #1;
      reset = 1'b0;
   endtask

   // One isolated access with cycle-by-cycle waveform checks; cycle 0 is the request cycle.
   task automatic check_access(input logic [1:0] port, input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [7:0] wd, input logic [7:0] exp_rd);
      logic act;
      @(posedge clk_chipset); #1;
      drive_req(port, we, addr, wd, 1'b1);
      exp_q.push_back({port, exp_rd});
      for (int cyc = 0; cyc <= W + 3; cyc++) begin
         @(negedge clk_chipset);
         act = (cyc >= 1) && (cyc <= W + 2);
         check("busy", busy, act);
         check("grant", grant, act ? port : 2'd0);
         check("we_n", sram_we_n, !(we && cyc >= 2 && cyc <= W + 1));
         check("dq_oe", sram_dq_oe, we && act);
         check("ack", port_ack(port), cyc == W + 2);
         if (act) check("addr", sram_addr, addr);
         if (we && act) check("dq_o", sram_dq_o, wd);
         if (cyc == W + 2) begin
            @(posedge clk_chipset); #1;
            drive_req(port, 1'b0, '0, '0, 1'b0);
         end
      end
   endtask

   // Holds the listed ports' read requests until n acks are seen, then releases them.
   task automatic run_contention(input logic use_v, input int n);
      int guard = 0;
      ack_log.delete();
      @(posedge clk_chipset); #1;
      v_req = use_v; v_addr = 21'h00045;
      c_req = 1'b1;  c_we = 1'b0; c_addr = 21'h00010;
      d_req = 1'b1;  d_we = 1'b0; d_addr = 21'h000FF;
      while (ack_log.size() < n && guard < 400) begin
         @(negedge clk_chipset); #1;
         guard++;
      end
      @(posedge clk_chipset); #1;
      v_req = 1'b0; c_req = 1'b0; d_req = 1'b0;
      check("ack_count", ack_log.size(), n);
      guard = 0;
      while (busy && guard < 20) begin
         @(negedge clk_chipset);
         guard++;
      end
      check("idle_after", busy, 1'b0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0]        port;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        wdata;
      logic [7:0]        exp_rdata;
   } vec_t;

   vec_t       vecs [10];
   logic [1:0] order_vcd [10];
   logic [1:0] order_cd  [6];

   initial begin
      int ack_cnt, ack_at;
      vecs[0] = '{2'd2, 1'b0, 21'h12345, 8'h00, 8'hA5};
      vecs[1] = '{2'd2, 1'b1, 21'h00010, 8'h3C, 8'hA5};
      vecs[2] = '{2'd2, 1'b0, 21'h00010, 8'h00, 8'h3C};
      vecs[3] = '{2'd3, 1'b1, 21'h000FF, 8'h81, 8'h3C};
      vecs[4] = '{2'd3, 1'b0, 21'h000FF, 8'h00, 8'h81};
      vecs[5] = '{2'd1, 1'b0, 21'h00045, 8'h00, 8'hA5};
      vecs[6] = '{2'd1, 1'b0, 21'h1FF33, 8'h00, 8'hD3};
      vecs[7] = '{2'd3, 1'b0, 21'h12345, 8'h00, 8'hA5};
      vecs[8] = '{2'd2, 1'b1, 21'h1FF00, 8'h5E, 8'hA5};
      vecs[9] = '{2'd1, 1'b0, 21'h00000, 8'h00, 8'h5E};
      order_vcd = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3};
      order_cd  = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3};

      reset = 1'b1;
      v_req = 1'b0; v_addr = '0;
      c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      repeat (3) @(posedge clk_chipset);
      #1 reset = 1'b0;

      ctx = "reset";
      @(negedge clk_chipset);
      check("state", dbg_state, 2'd0);
      check("we_n", sram_we_n, 1'b1);
      check("dq_oe", sram_dq_oe, 1'b0);
      check("addr", sram_addr, 0);
      check("dq_o", sram_dq_o, 0);
      check("rdata", rdata, 0);
      check("acks", {v_ack, c_ack, d_ack}, 0);
      check("busy", busy, 1'b0);
      check("grant", grant, 2'd0);

      for (int i = 0; i < 10; i++) begin
         ctx = $sformatf("vec%0d", i);
         check_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
      end
      ctx = "write_mem";
      check("mem10", mem[8'h10], 8'h3C);

      // V, C and D contend from reset: video bursts of four, C/D alternate in between.
      ctx = "vcd";
      apply_reset();
      for (int i = 0; i < 10; i++)
         exp_q.push_back({order_vcd[i], order_vcd[i] == 2'd1 ? 8'hA5 : (order_vcd[i] == 2'd2 ? 8'h3C : 8'h81)});
      run_contention(1'b1, 10);
      for (int i = 0; i < 10 && i < ack_log.size(); i++) check($sformatf("order%0d", i), ack_log[i], order_vcd[i]);

      ctx = "cd_rr";
      apply_reset();
      for (int i = 0; i < 6; i++) exp_q.push_back({order_cd[i], order_cd[i] == 2'd2 ? 8'h3C : 8'h81});
      run_contention(1'b0, 6);
      for (int i = 0; i < 6 && i < ack_log.size(); i++) check($sformatf("order%0d", i), ack_log[i], order_cd[i]);

      // Reset lands in the first ACCESS cycle of a D write; no ack may follow.
      ctx = "rst_abort";
      @(posedge clk_chipset); #1;
      drive_req(2'd3, 1'b1, 21'h00033, 8'h77, 1'b1);
      @(posedge clk_chipset); #1;
      @(posedge clk_chipset); #1;
      check("we_n_in_access", sram_we_n, 1'b0);
      reset = 1'b1;
      drive_req(2'd3, 1'b0, '0, '0, 1'b0);
      @(posedge clk_chipset); #1;
      reset = 1'b0;
      @(negedge clk_chipset);
      check("state", dbg_state, 2'd0);
      check("we_n", sram_we_n, 1'b1);
      check("dq_oe", sram_dq_oe, 1'b0);
      check("d_ack", d_ack, 1'b0);
      check("busy", busy, 1'b0);
      repeat (6) @(negedge clk_chipset);
      check("d_ack_late", d_ack, 1'b0);
      ctx = "after_abort";
      check_access(2'd2, 1'b0, 21'h12345, 8'h00, 8'hA5);

      // C drops its request and changes address right after the grant.
      ctx = "c_drop";
      @(posedge clk_chipset); #1;
      drive_req(2'd2, 1'b0, 21'h12345, 8'h00, 1'b1);
      exp_q.push_back({2'd2, 8'hA5});
      @(posedge clk_chipset); #1;
      drive_req(2'd2, 1'b0, 21'h00010, 8'h00, 1'b0);
      ack_cnt = 0;
      ack_at  = 0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk_chipset);
         if (c_ack) begin
            ack_cnt++;
            ack_at = cyc;
         end
      end
      check("ack_count", ack_cnt, 1);
      check("ack_cycle", ack_at, W + 2);
      check("busy_end", busy, 1'b0);
      check("rdata", rdata, 8'hA5);

      ctx = "final";
      repeat (3) @(negedge clk_chipset);
      check("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
